// File: rtl/battleship_turn_controller.sv
// Game sequencer for player-vs-PC battleship: ship-count decision, placement,
// alternating firing turns with a per-turn countdown, and win/lose tracking.
module battleship_turn_controller #(
  parameter int unsigned MAX_SHIPS    = 5,
  parameter int unsigned TURN_SECONDS = 15,
  parameter int unsigned TIMER_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ships_decided,
  input  logic [2:0]         player_amount_ships,
  input  logic               player_place,
  input  logic               player_fire,
  input  logic               pc_fire,
  input  logic               shot_hit,
  input  logic               tick_1s,
  input  logic               restart,
  output logic               decision,
  output logic               place_en,
  output logic               player_turn,
  output logic               pc_turn,
  output logic               auto_fire,
  output logic [TIMER_W-1:0] timer_sec,
  output logic [2:0]         ships_total,
  output logic [2:0]         player_hits,
  output logic [2:0]         pc_hits,
  output logic               game_won,
  output logic               game_lost,
  output logic [2:0]         state_code
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [2:0] {
    S_DECIDE = 3'd0,
    S_PLACE  = 3'd1,
    S_PLAYER = 3'd2,
    S_PC     = 3'd3,
    S_WIN    = 3'd4,
    S_LOSE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0]   MAX_SHIPS_C = CNT_W'(MAX_SHIPS);
  localparam logic [TIMER_W-1:0] TURN_LOAD   = TIMER_W'(TURN_SECONDS);

  state_t             state, state_n;
  logic [CNT_W-1:0]   placed, placed_n;
  logic [CNT_W-1:0]   ships_n, player_hits_n, pc_hits_n;
  logic [TIMER_W-1:0] timer_n;
  logic               auto_fire_n;

  assign state_code = state;

  // Next-state and next-datapath decode; events outside their state fall through to defaults.
  always_comb begin
    state_n       = state;
    placed_n      = placed;
    ships_n       = ships_total;
    player_hits_n = player_hits;
    pc_hits_n     = pc_hits;
    timer_n       = timer_sec;
    auto_fire_n   = 1'b0;

    unique case (state)
      S_DECIDE: begin
        timer_n = '0;
        if (ships_decided && (player_amount_ships != '0)) begin
          ships_n  = (player_amount_ships > MAX_SHIPS_C) ? MAX_SHIPS_C : player_amount_ships;
          placed_n = '0;
          state_n  = S_PLACE;
        end
      end

      S_PLACE: begin
        timer_n = '0;
        if (player_place) begin
          placed_n = placed + CNT_W'(1);
          if (placed_n == ships_total) begin
            state_n = S_PLAYER;
            timer_n = TURN_LOAD;
          end
        end
      end

      S_PLAYER: begin
        // A committed shot takes priority over a same-cycle timeout.
        if (player_fire) begin
          if (shot_hit && (player_hits < ships_total)) begin
            player_hits_n = player_hits + CNT_W'(1);
          end
          timer_n = '0;
          state_n = (player_hits_n == ships_total) ? S_WIN : S_PC;
        end else if (tick_1s) begin
          if (timer_sec <= TIMER_W'(1)) begin
            timer_n     = '0;
            auto_fire_n = 1'b1;
            state_n     = S_PC;
          end else begin
            timer_n = timer_sec - TIMER_W'(1);
          end
        end
      end

      S_PC: begin
        timer_n = '0;
        if (pc_fire) begin
          if (shot_hit && (pc_hits < ships_total)) begin
            pc_hits_n = pc_hits + CNT_W'(1);
          end
          if (pc_hits_n == ships_total) begin
            state_n = S_LOSE;
          end else begin
            state_n = S_PLAYER;
            timer_n = TURN_LOAD;
          end
        end
      end

      S_WIN, S_LOSE: begin
        timer_n = '0;
        if (restart) begin
          ships_n       = '0;
          player_hits_n = '0;
          pc_hits_n     = '0;
          placed_n      = '0;
          state_n       = S_DECIDE;
        end
      end

      default: begin
        state_n = S_DECIDE;
        timer_n = '0;
      end
    endcase
  end

  // State, counters and registered flag outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_DECIDE;
      placed      <= '0;
      ships_total <= '0;
      player_hits <= '0;
      pc_hits     <= '0;
      timer_sec   <= '0;
      auto_fire   <= 1'b0;
      decision    <= 1'b1;
      place_en    <= 1'b0;
      player_turn <= 1'b0;
      pc_turn     <= 1'b0;
      game_won    <= 1'b0;
      game_lost   <= 1'b0;
    end else begin
      state       <= state_n;
      placed      <= placed_n;
      ships_total <= ships_n;
      player_hits <= player_hits_n;
      pc_hits     <= pc_hits_n;
      timer_sec   <= timer_n;
      auto_fire   <= auto_fire_n;
      decision    <= (state_n == S_DECIDE);
      place_en    <= (state_n == S_PLACE);
      player_turn <= (state_n == S_PLAYER);
      pc_turn     <= (state_n == S_PC);
      game_won    <= (state_n == S_WIN);
      game_lost   <= (state_n == S_LOSE);
    end
  end

endmodule

// File: tb/tb_battleship_turn_controller.sv
// Directed bench for battleship_turn_controller with hand-computed expectations.
module tb_battleship_turn_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       ships_decided;
  logic [2:0] player_amount_ships;
  logic       player_place;
  logic       player_fire;
  logic       pc_fire;
  logic       shot_hit;
  logic       tick_1s;
  logic       restart;
  logic       decision;
  logic       place_en;
  logic       player_turn;
  logic       pc_turn;
  logic       auto_fire;
  logic [3:0] timer_sec;
  logic [2:0] ships_total;
  logic [2:0] player_hits;
  logic [2:0] pc_hits;
  logic       game_won;
  logic       game_lost;
  logic [2:0] state_code;

  int n_vec = 0;
  int n_err = 0;

  battleship_turn_controller dut (
    .clk(clk), .rst(rst), .ships_decided(ships_decided),
    .player_amount_ships(player_amount_ships), .player_place(player_place),
    .player_fire(player_fire), .pc_fire(pc_fire), .shot_hit(shot_hit),
    .tick_1s(tick_1s), .restart(restart), .decision(decision),
    .place_en(place_en), .player_turn(player_turn), .pc_turn(pc_turn),
    .auto_fire(auto_fire), .timer_sec(timer_sec), .ships_total(ships_total),
    .player_hits(player_hits), .pc_hits(pc_hits), .game_won(game_won),
    .game_lost(game_lost), .state_code(state_code)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ships_decided = 0; player_amount_ships = 0; player_place = 0;
    player_fire = 0; pc_fire = 0; shot_hit = 0; tick_1s = 0; restart = 0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 0;
    step();
    rst = 1;
    step();
  endtask

  task automatic decide(input logic [2:0] n);
    player_amount_ships = n; ships_decided = 1;
    step();
    ships_decided = 0; player_amount_ships = 0;
  endtask

  task automatic place_one();
    player_place = 1; step(); player_place = 0;
  endtask

  task automatic fire_player(input logic hit);
    player_fire = 1; shot_hit = hit; step(); player_fire = 0; shot_hit = 0;
  endtask

  task automatic fire_pc(input logic hit);
    pc_fire = 1; shot_hit = hit; step(); pc_fire = 0; shot_hit = 0;
  endtask

  task automatic tick();
    tick_1s = 1; step(); tick_1s = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 0;
    step();
    n_vec++; if (state_code !== 3'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state_code); end
    n_vec++; if (decision !== 1'b1) begin n_err++; $display("FAIL reset_decision got %b want 1", decision); end
    n_vec++; if ({place_en, player_turn, pc_turn, auto_fire, game_won, game_lost} !== 6'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 000000", {place_en, player_turn, pc_turn, auto_fire, game_won, game_lost}); end
    n_vec++; if ({timer_sec, ships_total, player_hits, pc_hits} !== 13'd0) begin
      n_err++; $display("FAIL reset_counts got %h want 0", {timer_sec, ships_total, player_hits, pc_hits}); end
    rst = 1;
    step();
  endtask

  task automatic test_decide();
    decide(3'd0);
    n_vec++; if (state_code !== 3'd0) begin n_err++; $display("FAIL decide_zero got %0d want 0", state_code); end
    decide(3'd7);
    n_vec++; if (state_code !== 3'd1) begin n_err++; $display("FAIL decide_seven_state got %0d want 1", state_code); end
    n_vec++; if (ships_total !== 3'd5) begin n_err++; $display("FAIL decide_clamp got %0d want 5", ships_total); end
    apply_reset();
    decide(3'd3);
    n_vec++; if (state_code !== 3'd1) begin n_err++; $display("FAIL decide_three_state got %0d want 1", state_code); end
    n_vec++; if (ships_total !== 3'd3) begin n_err++; $display("FAIL decide_three_total got %0d want 3", ships_total); end
    n_vec++; if ({place_en, decision} !== 2'b10) begin n_err++; $display("FAIL decide_flags got %b want 10", {place_en, decision}); end
  endtask

  task automatic test_place();
    apply_reset();
    decide(3'd2);
    fire_player(1'b1);
    n_vec++; if (player_hits !== 3'd0) begin n_err++; $display("FAIL place_fire_ignored got %0d want 0", player_hits); end
    place_one();
    n_vec++; if (state_code !== 3'd1) begin n_err++; $display("FAIL place_first got %0d want 1", state_code); end
    place_one();
    n_vec++; if (state_code !== 3'd2) begin n_err++; $display("FAIL place_second got %0d want 2", state_code); end
    n_vec++; if (timer_sec !== 4'd15) begin n_err++; $display("FAIL place_timer got %0d want 15", timer_sec); end
    n_vec++; if ({player_turn, place_en} !== 2'b10) begin n_err++; $display("FAIL place_flags got %b want 10", {player_turn, place_en}); end
  endtask

  // Continues from PLAYER with ships_total=2.
  task automatic test_timeout();
    for (int i = 0; i < 14; i++) tick();
    n_vec++; if (timer_sec !== 4'd1) begin n_err++; $display("FAIL timeout_count got %0d want 1", timer_sec); end
    n_vec++; if (auto_fire !== 1'b0) begin n_err++; $display("FAIL timeout_early_auto got %b want 0", auto_fire); end
    tick();
    n_vec++; if (timer_sec !== 4'd0) begin n_err++; $display("FAIL timeout_zero got %0d want 0", timer_sec); end
    n_vec++; if (auto_fire !== 1'b1) begin n_err++; $display("FAIL timeout_auto got %b want 1", auto_fire); end
    n_vec++; if ({state_code, pc_turn} !== 4'b0111) begin n_err++; $display("FAIL timeout_state got %b want 0111", {state_code, pc_turn}); end
    n_vec++; if (player_hits !== 3'd0) begin n_err++; $display("FAIL timeout_hits got %0d want 0", player_hits); end
    tick();
    n_vec++; if (auto_fire !== 1'b0) begin n_err++; $display("FAIL timeout_pulse_width got %b want 0", auto_fire); end
    n_vec++; if (timer_sec !== 4'd0) begin n_err++; $display("FAIL timeout_pc_tick got %0d want 0", timer_sec); end
    fire_pc(1'b0);
    n_vec++; if ({state_code, timer_sec} !== 7'b010_1111) begin n_err++; $display("FAIL timeout_reload got %b want 0101111", {state_code, timer_sec}); end
  endtask

  // Continues from PLAYER with a fresh 15-second timer.
  task automatic test_fire_vs_timeout();
    for (int i = 0; i < 14; i++) tick();
    tick_1s = 1; player_fire = 1; shot_hit = 0;
    step();
    clear_inputs();
    n_vec++; if (auto_fire !== 1'b0) begin n_err++; $display("FAIL race_auto got %b want 0", auto_fire); end
    n_vec++; if ({state_code, player_hits} !== 6'b011_000) begin n_err++; $display("FAIL race_state got %b want 011000", {state_code, player_hits}); end
  endtask

  // Continues from PC with ships_total=2 and no hits yet.
  task automatic test_win();
    fire_pc(1'b0);
    fire_player(1'b1);
    n_vec++; if ({state_code, player_hits} !== 6'b011_001) begin n_err++; $display("FAIL win_first_hit got %b want 011001", {state_code, player_hits}); end
    fire_pc(1'b0);
    fire_player(1'b1);
    n_vec++; if ({state_code, player_hits, game_won} !== 7'b100_010_1) begin
      n_err++; $display("FAIL win_state got %b want 1000101", {state_code, player_hits, game_won}); end
    fire_pc(1'b1);
    n_vec++; if ({state_code, pc_hits} !== 6'b100_000) begin n_err++; $display("FAIL win_pc_ignored got %b want 100000", {state_code, pc_hits}); end
    restart = 1; step(); restart = 0;
    n_vec++; if ({state_code, decision, game_won} !== 5'b000_10) begin
      n_err++; $display("FAIL restart_state got %b want 00010", {state_code, decision, game_won}); end
    n_vec++; if ({ships_total, player_hits, pc_hits} !== 9'd0) begin
      n_err++; $display("FAIL restart_counts got %h want 0", {ships_total, player_hits, pc_hits}); end
    decide(3'd1);
    place_one();
    n_vec++; if (state_code !== 3'd2) begin n_err++; $display("FAIL restart_replace got %0d want 2", state_code); end
  endtask

  task automatic test_lose();
    apply_reset();
    decide(3'd1);
    place_one();
    fire_player(1'b0);
    fire_pc(1'b1);
    n_vec++; if ({state_code, pc_hits, game_lost, pc_turn} !== 8'b101_001_10) begin
      n_err++; $display("FAIL lose_state got %b want 10100110", {state_code, pc_hits, game_lost, pc_turn}); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    decide(3'd2);
    place_one();
    place_one();
    fire_player(1'b0);
    fire_pc(1'b1);
    fire_player(1'b0);
    n_vec++; if ({state_code, pc_hits} !== 6'b011_001) begin n_err++; $display("FAIL async_setup got %b want 011001", {state_code, pc_hits}); end
    #2 rst = 0;
    #1;
    n_vec++; if ({state_code, pc_hits, ships_total} !== 9'd0) begin
      n_err++; $display("FAIL async_immediate got %b want 0", {state_code, pc_hits, ships_total}); end
    n_vec++; if ({decision, pc_turn} !== 2'b10) begin n_err++; $display("FAIL async_flags got %b want 10", {decision, pc_turn}); end
    @(negedge clk);
    rst = 1;
    step();
    n_vec++; if ({state_code, decision} !== 4'b0001) begin n_err++; $display("FAIL async_release got %b want 0001", {state_code, decision}); end
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_decide();
    test_place();
    test_timeout();
    test_fire_vs_timeout();
    test_win();
    test_lose();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
